// File: rtl/fifo_serializer_if.sv
// Bundles the FIFO pop-side signals and the narrow val/rdy output stream of the
// serializer. The master modport is the serializer side; slave is the environment.
interface fifo_serializer_if #(
  parameter int p_entry_bits = 32,
  parameter int p_beat_bits  = 8
);
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic [p_entry_bits-1:0] fifo_rdata;
  logic                    ostream_val;
  logic                    ostream_rdy;
  logic [p_beat_bits-1:0]  ostream_msg;
  logic                    ostream_last;

  modport master (
    input  fifo_empty, fifo_rdata, ostream_rdy,
    output fifo_pop, ostream_val, ostream_msg, ostream_last
  );

  modport slave (
    output fifo_empty, fifo_rdata, ostream_rdy,
    input  fifo_pop, ostream_val, ostream_msg, ostream_last
  );
endinterface

// File: rtl/fifo_serializer.sv
// Drains wide FIFO entries and emits them LSB-first as narrow val/rdy beats with a
// last-beat marker; the next entry is reloaded on the final handshake, so no bubbles.
module fifo_serializer #(
  parameter int p_entry_bits = 32,
  parameter int p_beat_bits  = 8
) (
  input logic               clk,
  input logic               rst,
  fifo_serializer_if.master bus
);
  localparam int N     = p_entry_bits / p_beat_bits;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [p_entry_bits-1:0] shreg;
  logic [CNT_W-1:0]        count;
  logic                    last_beat;
  logic                    load;
  logic                    shift;
  logic                    pop;

  assign last_beat = (count == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A reload on the last handshake keeps the stream continuous across entries.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.fifo_empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.ostream_rdy) begin
          if (!last_beat) begin
            shift = 1'b1;
          end else if (!bus.fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The shift register is cleared too, so the beat output reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
    end else if (load) begin
      shreg <= bus.fifo_rdata;
      count <= '0;
    end else if (shift) begin
      shreg <= shreg >> p_beat_bits;
      count <= count + CNT_W'(1);
    end
  end

  assign bus.fifo_pop     = pop & ~rst;
  assign bus.ostream_val  = (state == BUSY);
  assign bus.ostream_msg  = shreg[p_beat_bits-1:0];
  assign bus.ostream_last = (state == BUSY) & last_beat;
endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: a 32/8 instance and a 17/17 instance, each fed by a small
// FIFO model, with a scoreboard of expected beats consumed by per-instance monitors.
module tb_fifo_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_serializer_if #(.p_entry_bits(32), .p_beat_bits(8))  if0 ();
  fifo_serializer_if #(.p_entry_bits(17), .p_beat_bits(17)) if1 ();

  fifo_serializer #(.p_entry_bits(32), .p_beat_bits(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  fifo_serializer #(.p_entry_bits(17), .p_beat_bits(17)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // FIFO models, 16 deep, never reset by the serializer's rst
  logic        push0 = 1'b0;
  logic [31:0] wdata0 = '0;
  logic [31:0] mem0 [16];
  logic [4:0]  wp0 = '0;
  logic [4:0]  rp0 = '0;
  logic        push1 = 1'b0;
  logic [16:0] wdata1 = '0;
  logic [16:0] mem1 [16];
  logic [4:0]  wp1 = '0;
  logic [4:0]  rp1 = '0;

  always @(posedge clk) begin
    if (push0) begin
      mem0[wp0[3:0]] <= wdata0;
      wp0 <= wp0 + 5'd1;
    end
    if (if0.fifo_pop) rp0 <= rp0 + 5'd1;
    if (push1) begin
      mem1[wp1[3:0]] <= wdata1;
      wp1 <= wp1 + 5'd1;
    end
    if (if1.fifo_pop) rp1 <= rp1 + 5'd1;
  end

  assign if0.fifo_empty = (wp0 == rp0);
  assign if0.fifo_rdata = mem0[rp0[3:0]];
  assign if1.fifo_empty = (wp1 == rp1);
  assign if1.fifo_rdata = mem1[rp1[3:0]];

  int nvec = 0;
  int nerr = 0;
  logic [8:0]  exp0 [$];
  logic [17:0] exp1 [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Reference: an entry becomes four bytes, low byte first, last flag on the top byte.
  task automatic push_entry0(input logic [31:0] e);
    push0  = 1'b1;
    wdata0 = e;
    for (int b = 0; b < 4; b++) exp0.push_back({b == 3, e[8*b +: 8]});
  endtask

  task automatic push_entry1(input logic [16:0] e);
    push1  = 1'b1;
    wdata1 = e;
    exp1.push_back({1'b1, e});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int fcount0();
    logic [4:0] d;
    d = wp0 - rp0;
    return int'(d);
  endfunction

  // Monitors: consume one expected beat per handshake.
  always @(negedge clk) begin
    logic [8:0] e;
    chk("pop_while_empty0", 64'(if0.fifo_pop & if0.fifo_empty), 64'd0);
    if (if0.ostream_val && if0.ostream_rdy) begin
      if (exp0.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_beat0: got %0h, required no beat", if0.ostream_msg);
      end else begin
        e = exp0.pop_front();
        chk("beat_msg0", 64'(if0.ostream_msg), 64'(e[7:0]));
        chk("beat_last0", 64'(if0.ostream_last), 64'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (if1.ostream_val && if1.ostream_rdy) begin
      if (exp1.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_beat1: got %0h, required no beat", if1.ostream_msg);
      end else begin
        e = exp1.pop_front();
        chk("beat_msg1", 64'(if1.ostream_msg), 64'(e[16:0]));
        chk("beat_last1", 64'(if1.ostream_last), 64'(e[17]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] be [4];
    logic [8:0] f;
    int guard;
    be = '{8'hef, 8'hbe, 8'had, 8'hde};
    if0.ostream_rdy = 1'b0;
    if1.ostream_rdy = 1'b0;
    rst = 1'b1;
    #1;

    // reset with a non-empty FIFO
    push_entry0(32'h11223344);
    tick;
    push0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_val", 64'(if0.ostream_val), 64'd0);
      chk("rst_last", 64'(if0.ostream_last), 64'd0);
      chk("rst_msg", 64'(if0.ostream_msg), 64'd0);
      chk("rst_pop", 64'(if0.fifo_pop), 64'd0);
      chk("rst_fifo_count", 64'(fcount0()), 64'd1);
      tick;
    end
    if0.ostream_rdy = 1'b1;
    if1.ostream_rdy = 1'b1;
    rst = 1'b0;
    #1;
    chk("post_rst_pop", 64'(if0.fifo_pop), 64'd1);
    repeat (6) tick;
    chk("post_rst_idle", 64'(if0.ostream_val), 64'd0);

    // single entry
    push_entry0(32'hdeadbeef);
    tick;
    push0 = 1'b0;
    chk("single_pop", 64'(if0.fifo_pop), 64'd1);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("single_val", 64'(if0.ostream_val), 64'd1);
      chk("single_msg", 64'(if0.ostream_msg), 64'(be[i]));
      chk("single_last", 64'(if0.ostream_last), 64'(i == 3));
      tick;
    end
    chk("single_val_after", 64'(if0.ostream_val), 64'd0);
    chk("single_empty_after", 64'(if0.fifo_empty), 64'd1);

    // backpressure on beat 0xbe
    push_entry0(32'hdeadbeef);
    tick;
    push0 = 1'b0;
    tick;
    chk("bp_first", 64'(if0.ostream_msg), 64'hef);
    tick;
    if0.ostream_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_val", 64'(if0.ostream_val), 64'd1);
      chk("bp_msg", 64'(if0.ostream_msg), 64'hbe);
      chk("bp_last", 64'(if0.ostream_last), 64'd0);
      if (i == 2) if0.ostream_rdy = 1'b1;
      tick;
    end
    chk("bp_msg_ad", 64'(if0.ostream_msg), 64'had);
    tick;
    chk("bp_msg_de", 64'(if0.ostream_msg), 64'hde);
    chk("bp_last_de", 64'(if0.ostream_last), 64'd1);
    tick;
    chk("bp_val_after", 64'(if0.ostream_val), 64'd0);

    // back-to-back entries
    if0.ostream_rdy = 1'b0;
    push_entry0(32'h03020100);
    tick;
    push_entry0(32'h07060504);
    tick;
    push0 = 1'b0;
    if0.ostream_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_val", 64'(if0.ostream_val), 64'd1);
      chk("b2b_msg", 64'(if0.ostream_msg), 64'(i));
      chk("b2b_last", 64'(if0.ostream_last), 64'(i == 3 || i == 7));
      chk("b2b_pop", 64'(if0.fifo_pop), 64'(i == 3));
      tick;
    end
    chk("b2b_val_after", 64'(if0.ostream_val), 64'd0);

    // reset mid-entry, with a second entry waiting in the FIFO
    push_entry0(32'hdeadbeef);
    tick;
    push_entry0(32'hcafef00d);
    tick;
    push0 = 1'b0;
    chk("mid_first", 64'(if0.ostream_msg), 64'hef);
    tick;
    chk("mid_second", 64'(if0.ostream_msg), 64'hbe);
    tick;
    rst = 1'b1;
    do f = exp0.pop_front(); while (!f[8] && exp0.size() != 0);
    #1;
    chk("mid_val_drop", 64'(if0.ostream_val), 64'd0);
    chk("mid_last_drop", 64'(if0.ostream_last), 64'd0);
    chk("mid_msg_clear", 64'(if0.ostream_msg), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("mid_pop", 64'(if0.fifo_pop), 64'd0);
      chk("mid_fifo_count", 64'(fcount0()), 64'd1);
    end
    rst = 1'b0;
    repeat (6) tick;
    chk("mid_drained_empty", 64'(if0.fifo_empty), 64'd1);
    chk("mid_drained_val", 64'(if0.ostream_val), 64'd0);

    // N = 1 instance: one beat per cycle, all marked last
    if1.ostream_rdy = 1'b0;
    push_entry1(17'h1a5a5);
    tick;
    push_entry1(17'h00f0f);
    tick;
    push_entry1(17'h13579);
    tick;
    push1 = 1'b0;
    if1.ostream_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("n1_val", 64'(if1.ostream_val), 64'd1);
      chk("n1_last", 64'(if1.ostream_last), 64'd1);
      tick;
    end
    chk("n1_val_after", 64'(if1.ostream_val), 64'd0);

    // random pushes, data and backpressure
    for (int i = 0; i < 30; i++) begin
      if0.ostream_rdy = 1'($urandom_range(0, 1));
      if (fcount0() < 12 && $urandom_range(0, 1) == 1) push_entry0($urandom);
      else push0 = 1'b0;
      tick;
    end
    push0 = 1'b0;
    if0.ostream_rdy = 1'b1;
    guard = 0;
    while ((exp0.size() != 0 || if0.ostream_val) && guard < 300) begin
      tick;
      guard++;
    end
    chk("rand_drain_timeout", 64'(guard < 300), 64'd1);
    chk("rand_left0", 64'(exp0.size()), 64'd0);
    chk("rand_left1", 64'(exp1.size()), 64'd0);
    chk("rand_empty", 64'(if0.fifo_empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
